afifo_wr_mux: RTL

Write-side front end of the async FIFO. Merges NUM_CH producer channels, each with a valid/ready handshake, onto the single winc/wdata/wfull write port. Arbitration is round-robin with an optional burst lock. Sits entirely in the write clock domain, directly in front of the FIFO write port.

---
 rtl/afifo_wr_mux.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/afifo_wr_mux.sv
// afifo_wr_mux: write-side front end of the async FIFO.
// Merges NUM_CH valid/ready producer channels onto the single winc/wdata/wfull
// write port using round-robin arbitration with an optional burst lock of up to
// BURST_LEN consecutive beats per channel. Zero-latency datapath, wclk domain only.
// Optional build macro: AFIFO_WR_MUX_STATS_EN adds saturating per-channel beat
// counters (stat_beats) and a stall-cycle counter (stat_stall).
module afifo_wr_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                           wclk,
    input  logic                           wrst_n,
    input  logic [NUM_CH-1:0]              ch_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
    output logic [NUM_CH-1:0]              ch_ready,
    input  logic                           wfull,
    output logic                           winc,
    output logic [DATA_WIDTH-1:0]          wdata,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] owner,
    output logic                           locked
`ifdef AFIFO_WR_MUX_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]           stat_beats,
    output logic [15:0]                    stat_stall
`endif
);

    localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    // Reject out-of-range configurations at elaboration time.
    if (NUM_CH < 2 || NUM_CH > 16 || BURST_LEN < 1 || BURST_LEN > 256 || ADDR_WIDTH < 1) begin : g_param_check
        $error("afifo_wr_mux: parameter out of range");
    end

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic [OW-1:0] gnt;
    logic          grant_valid;
    logic [DATA_WIDTH-1:0] ch_words [NUM_CH];

    // Next channel index with explicit wrap so non-power-of-2 NUM_CH works.
    function automatic logic [OW-1:0] next_ch(input logic [OW-1:0] c);
        return (int'(c) == NUM_CH - 1) ? '0 : c + 1'b1;
    endfunction

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_words
        assign ch_words[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grant selection: locked owner in LOCK, rotating priority search in IDLE.
    always_comb begin
        logic [OW:0] sum;
        logic        found;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        gnt         = rr_ptr_q;
        grant_valid = 1'b0;
        found       = 1'b0;
        sum         = '0;
        if (state_q == ST_LOCK) begin
            gnt         = owner_q;
            grant_valid = ch_valid[owner_q];
        end else begin
            grant_valid = |ch_valid;
            for (int k = 0; k < NUM_CH; k++) begin
                sum = {1'b0, rr_ptr_q} + (OW+1)'(k);
                if (sum >= (OW+1)'(NUM_CH)) sum = sum - (OW+1)'(NUM_CH);
                if (!found && ch_valid[sum[OW-1:0]]) begin
                    found = 1'b1;
                    gnt   = sum[OW-1:0];
                end
            end
        end
    end

    // Zero-latency write port; reset gates the strobes combinationally.
    always_comb begin
        ch_ready      = '0;
        ch_ready[gnt] = wrst_n & grant_valid & ~wfull;
    end

    assign winc   = wrst_n & grant_valid & ch_valid[gnt] & ~wfull;
    assign wdata  = ch_words[gnt];
    assign owner  = gnt;
    assign locked = (state_q == ST_LOCK);

    // Arbitration FSM: lock a channel for a burst, rotate on burst end or gap.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (winc) begin
                    if (BURST_LEN > 1) begin
                        state_d    = ST_LOCK;
                        owner_d    = gnt;
                        beat_cnt_d = CW'(1);
                    end else begin
                        rr_ptr_d = next_ch(gnt);
                    end
                end
            end
            ST_LOCK: begin
                if (!wfull) begin
                    if (ch_valid[owner_q] && beat_cnt_q != CW'(BURST_LEN - 1)) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end else begin
                        // Last beat of the burst, or the owner went idle: release.
                        state_d    = ST_IDLE;
                        rr_ptr_d   = next_ch(owner_q);
                        beat_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef AFIFO_WR_MUX_STATS_EN
    logic [NUM_CH*16-1:0] stat_beats_q;
    logic [15:0]          stat_stall_q;

    // Saturating transfer and stall counters.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            // NOTE: the counter bank is software-visible, so it is reset rather than left as uninitialised storage.
            stat_beats_q <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (winc && gnt == OW'(i) && stat_beats_q[i*16 +: 16] != 16'hFFFF) begin
                    stat_beats_q[i*16 +: 16] <= stat_beats_q[i*16 +: 16] + 16'd1;
                end
            end
            if ((|ch_valid) && wfull && stat_stall_q != 16'hFFFF) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
